// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared RV32 types. Holds the machine word type, the RV32M
//               funct3 encoding used by the multiply/divide unit, and the
//               state encoding of the iterative multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    // RV32M funct3 codes. Bit 2 separates divide/remainder from multiply.
    typedef enum logic [2:0] {
        c_OP_MUL    = 3'd0,
        c_OP_MULH   = 3'd1,
        c_OP_MULHSU = 3'd2,
        c_OP_MULHU  = 3'd3,
        c_OP_DIV    = 3'd4,
        c_OP_DIVU   = 3'd5,
        c_OP_REM    = 3'd6,
        c_OP_REMU   = 3'd7
    } muldiv_funct3_t;

    // Sequencer states, explicitly encoded.
    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t c_ST_IDLE = 2'd0;
    localparam muldiv_state_t c_ST_BUSY = 2'd1;
    localparam muldiv_state_t c_ST_FIX  = 2'd2;
    localparam muldiv_state_t c_ST_DONE = 2'd3;

    // True for the divide/remainder group.
    function automatic logic op_is_div(input muldiv_funct3_t f);
        return f[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sign_fix
// Description : Final correction step of the multiply/divide unit. Applies
//               the result sign to the magnitude computed by the iterative
//               loop and selects the half / quotient / remainder for the op.
//               Purely combinational.
// Ports       : op     - funct3 of the operation in flight
//               hi, lo - product high/low halves, or remainder/quotient
//               sa, sb - operand was treated as negative (signed op, msb set)
//               bzero  - divisor was zero
//               result - corrected, selected result word
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  muldiv_funct3_t     op,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    input  logic               sa,
    input  logic               sb,
    input  logic               bzero,
    output logic [WIDTH-1:0]   result
);

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Unsigned ops arrive with sa=sb=0, so one signed path serves every op.
    assign w_prod     = {hi, lo};
    assign w_prod_fix = (sa ^ sb) ? (~w_prod + 1'b1) : w_prod;
    // Division by zero keeps the all-ones quotient regardless of operand signs.
    assign w_quo_fix  = ((sa ^ sb) && !bzero) ? (~lo + 1'b1) : lo;
    // Remainder follows the sign of the dividend.
    assign w_rem_fix  = sa ? (~hi + 1'b1) : hi;

    always_comb begin
        result = '0;
        case (op)
            c_OP_MUL:                         result = w_prod_fix[WIDTH-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: result = w_prod_fix[2*WIDTH-1:WIDTH];
            c_OP_DIV, c_OP_DIVU:              result = w_quo_fix;
            c_OP_REM, c_OP_REMU:              result = w_rem_fix;
            default:                          result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//               restoring divide on operand magnitudes, one bit per cycle,
//               followed by a sign-correction cycle.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               start        - request, accepted when start && ready && !flush
//               op           - RV32M funct3
//               a, b         - rs1 / rs2, sampled on accept only
//               flush        - abort in-flight operation, return to idle
//               ready        - unit idle
//               done         - one-cycle result-valid pulse
//               result       - held from done until the next accept
// Config      : MULDIV_EARLY_OUT_EN - divide by zero and signed divide
//               overflow complete straight from IDLE to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int c_CW = $clog2(WIDTH);

    muldiv_state_t      r_state;
    logic [c_CW-1:0]    r_cnt;
    muldiv_funct3_t     r_op;
    logic [WIDTH-1:0]   r_hi;      // product high half / partial remainder
    logic [WIDTH-1:0]   r_lo;      // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0]   r_b;       // |b|
    logic               r_sa;
    logic               r_sb;
    logic               r_bzero;
    logic               r_ready;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    muldiv_funct3_t     w_op;
    logic               w_a_signed;
    logic               w_b_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [WIDTH-1:0]   w_fix_result;

    assign w_op       = muldiv_funct3_t'(op);
    assign w_a_signed = (w_op == c_OP_MUL) || (w_op == c_OP_MULH) || (w_op == c_OP_MULHSU) ||
                        (w_op == c_OP_DIV) || (w_op == c_OP_REM);
    assign w_b_signed = (w_op == c_OP_MUL) || (w_op == c_OP_MULH) ||
                        (w_op == c_OP_DIV) || (w_op == c_OP_REM);
    assign w_sa       = w_a_signed & a[WIDTH-1];
    assign w_sb       = w_b_signed & b[WIDTH-1];
    assign w_a_mag    = w_sa ? (~a + 1'b1) : a;
    assign w_b_mag    = w_sb ? (~b + 1'b1) : b;

    // Multiply step: conditional add of |b| into the high half, then shift
    // the whole {carry, hi, lo} right by one.
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Restoring divide step on a WIDTH+1 bit trial remainder; msb of the
    // difference is the borrow that decides restore vs keep.
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};

`ifdef MULDIV_EARLY_OUT_EN
    logic               w_bzero_in;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_early_result;

    assign w_bzero_in = (b == '0);
    assign w_ovf      = ((w_op == c_OP_DIV) || (w_op == c_OP_REM)) &&
                        (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    // Quotient: all ones on /0, most-negative on overflow (equals a).
    // Remainder: a on /0, zero on overflow.
    assign w_early_result = (w_op == c_OP_DIV || w_op == c_OP_DIVU)
                          ? (w_bzero_in ? {WIDTH{1'b1}} : a)
                          : (w_bzero_in ? a : {WIDTH{1'b0}});
`endif

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .op     (r_op),
        .hi     (r_hi),
        .lo     (r_lo),
        .sa     (r_sa),
        .sb     (r_sb),
        .bzero  (r_bzero),
        .result (w_fix_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_op     <= c_OP_MUL;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_bzero  <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            // Abort wins over everything, including a same-cycle start.
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op    <= w_op;
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_bzero <= (b == '0);
                        r_hi    <= '0;
                        r_lo    <= w_a_mag;
                        r_b     <= w_b_mag;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                        if (op_is_div(w_op) && (w_bzero_in || w_ovf)) begin
                            r_result <= w_early_result;
                            r_done   <= 1'b1;
                            r_state  <= c_ST_DONE;
                        end else begin
                            r_state  <= c_ST_BUSY;
                        end
`else
                        r_state <= c_ST_BUSY;
`endif
                    end
                end
                c_ST_BUSY: begin
                    if (op_is_div(r_op)) begin
                        if (!w_div_diff[WIDTH]) begin
                            r_hi <= w_div_diff[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hi <= w_div_shift[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_mul_sum[WIDTH:1];
                        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CW'(WIDTH-1)) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    r_result <= w_fix_result;
                    r_done   <= 1'b1;
                    r_state  <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Table of directed
//               operations with hand-computed results and latencies, then
//               hand-written flush, reset and back-to-back sequences.
// Config      : honours MULDIV_EARLY_OUT_EN for expected latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import rv32i_types::*;

    localparam int WIDTH   = 32;
    localparam int NVEC    = 18;
    localparam int TIMEOUT = 100;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    rv32i_word   a;
    rv32i_word   b;
    logic        flush;
    logic        ready;
    logic        done;
    rv32i_word   result;

    int total;
    int bad;

    typedef struct {
        logic [2:0] op;
        rv32i_word  a;
        rv32i_word  b;
        rv32i_word  exp;
        logic       early;   // eligible for the early-out path
    } vec_t;

    vec_t vecs [NVEC];

    muldiv_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done. lat counts cycles from
    // the accept cycle to the done cycle.
    task automatic run_op(input logic [2:0] o, input rv32i_word x, input rv32i_word y,
                          output rv32i_word res, output int lat);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat   = 1;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    initial begin
        rv32i_word res;
        int        lat;
        int        exp_lat;
        int        ndone;
        int        t1;
        int        t2;
        int        cyc;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0}; // MUL
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0}; // MULH
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0}; // MULHU
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0}; // MULHSU
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0}; // DIV -7/2
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0}; // REM -7/2
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0}; // DIVU
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0}; // REMU
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1}; // DIVU /0
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1'b1}; // REM /0
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1}; // DIV ovf
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1}; // REM ovf
        vecs[12] = '{3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1'b1}; // DIV -5/0
        vecs[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1'b1}; // REM -5/0
        vecs[14] = '{3'd0, 32'h1234_5678,  32'h10,        32'h2345_6780, 1'b0}; // MUL
        vecs[15] = '{3'd1, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b0}; // MULH -1*1
        vecs[16] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0}; // DIV 7/-2
        vecs[17] = '{3'd3, 32'h8000_0000,  32'd2,         32'd1,         1'b0}; // MULHU

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ready",  {31'd0, ready}, 32'd1);
        check("reset_done",   {31'd0, done},  32'd0);
        check("reset_result", result,         32'd0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
`ifdef MULDIV_EARLY_OUT_EN
            exp_lat = vecs[i].early ? 1 : 34;
`else
            exp_lat = 34;
`endif
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, exp_lat);
        end

        // Flush at counter=10: no done, back to idle, result kept.
        run_op(3'd5, 32'd100, 32'd7, res, lat);      // result becomes 14
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        @(negedge clk);                              // BUSY, counter 0
        start = 1'b0;
        repeat (10) @(negedge clk);                  // BUSY, counter 10
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready",  {31'd0, ready}, 32'd1);
        check("flush_done",   {31'd0, done},  32'd0);
        check("flush_result", result,         32'd14);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush_no_done", ndone, 0);

        // flush and start together in IDLE: not accepted.
        start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_ready", {31'd0, ready}, 32'd1);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush_start_no_done", ndone, 0);

        // Asynchronous reset mid-BUSY, between clock edges.
        start = 1'b1; op = 3'd0; a = 32'd4; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ready",  {31'd0, ready}, 32'd1);
        check("async_rst_done",   {31'd0, done},  32'd0);
        check("async_rst_result", result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back with start held high: two done pulses 35 cycles apart.
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
        t1 = -1; t2 = -1; cyc = 0;
        while (t2 < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (t1 < 0) t1 = cyc;
                else        t2 = cyc;
            end
        end
        start = 1'b0;
        check("b2b_second_seen", {31'd0, (t2 >= 0)}, 32'd1);
        check("b2b_spacing", t2 - t1, 35);
        check("b2b_result", result, 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
